// File: rtl/fifo_level_if.sv
// fifo_level_if: one valid/ready/data handshake channel.
// Ports: valid and data are driven by the producer (master) and ready by the consumer (slave).
// One instance carries the write side and a second instance carries the read side of a FIFO.
interface fifo_level_if #(
  parameter type TYPE = logic
);
  logic valid;
  logic ready;
  TYPE  data;

  // The producer owns valid and data, and it samples ready.
  modport master (
    output valid,
    output data,
    input  ready
  );

  // The consumer samples valid and data, and it owns ready.
  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/fifo_level.sv
// fifo_level: a synchronous FIFO with any DEPTH >= 1, registered occupancy, and almost-full/almost-empty flags.
// Latency: a stored entry appears at rd.data one cycle after it is written. With FALL_THROUGH=1, an empty FIFO presents wr.data combinationally.
// Backpressure: wr.ready is low when the FIFO is full or when flush is high. rd.valid is low when flush is high.
//
// Ports:
//   clk, rstn     clock (rising edge); asynchronous active-low reset
//   flush         synchronous discard of all stored entries
//   wr (slave)    write channel: valid/data in, ready out
//   rd (master)   read channel: valid/data out, ready in
//   count         registered occupancy, 0..DEPTH
//   almost_full   registered, count >= AF_LEVEL
//   almost_empty  registered, count <= AE_LEVEL
//   peak          defined only with FIFO_LEVEL_PEAK_EN: the largest occupancy since reset or flush
//
// Optional feature macro: FIFO_LEVEL_PEAK_EN adds the peak output and its register.
module fifo_level #(
  parameter int  DATA_WIDTH   = 1,
  parameter type TYPE         = logic [DATA_WIDTH-1:0],
  parameter int  DEPTH        = 4,
  parameter int  FALL_THROUGH = 0,
  parameter int  AF_LEVEL     = DEPTH - 1,
  parameter int  AE_LEVEL     = 1,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  fifo_level_if.slave   wr,
  fifo_level_if.master  rd,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty
`ifdef FIFO_LEVEL_PEAK_EN
  ,
  output logic [CW-1:0] peak
`endif
);

  // ---------------------------------------------------------------------
  // Elaboration checks on the parameters
  // ---------------------------------------------------------------------
  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "fifo_level: DEPTH must be >= 1");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_level: AF_LEVEL must be <= DEPTH");
  end
  if (AE_LEVEL > DEPTH) begin : g_bad_ae
    $fatal(1, "fifo_level: AE_LEVEL must be <= DEPTH");
  end

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam bit            FT      = (FALL_THROUGH != 0);
  localparam bit            AF_RST  = (AF_LEVEL == 0);

  logic          empty;
  logic          w_hs;
  logic          r_hs;
  logic          bypass;
  logic          wr_en;
  logic          rd_en;
  logic [CW-1:0] count_next;
  TYPE           head;

  // ---------------------------------------------------------------------
  // Handshake and data path
  // ---------------------------------------------------------------------
  assign empty    = (count == '0);

  // Flush forces both ready and valid low, so no transfer can complete while the FIFO is being cleared.
  assign wr.ready = !flush && (count < DEPTH_C);
  assign rd.valid = !flush && (!empty || (FT && wr.valid));

  assign w_hs     = wr.valid && wr.ready;
  assign r_hs     = rd.valid && rd.ready;

  // When the FIFO is empty and in fall-through mode, a read handshake can only be serving the incoming word.
  // That word passes straight through and never touches storage, the pointers, or count.
  assign bypass   = FT && empty && w_hs && r_hs;
  assign wr_en    = w_hs && !bypass;
  assign rd_en    = r_hs && !bypass;

  assign rd.data  = (FT && empty) ? wr.data : head;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // ---------------------------------------------------------------------
  // Occupancy and flags
  // ---------------------------------------------------------------------
  // The flags are computed from count_next, so they change on the same edge as count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count        <= '0;
      almost_full  <= AF_RST;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_next;
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
    end
  end

`ifdef FIFO_LEVEL_PEAK_EN
  // count_next is already 0 during a flush. A separate clear is still needed
  // because peak would otherwise only ever increase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak <= '0;
    end else if (flush) begin
      peak <= '0;
    end else if (count_next > peak) begin
      peak <= count_next;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  if (DEPTH == 1) begin : g_single
    // A single entry needs no pointers. count alone tells whether the entry is occupied.
    TYPE mem_q;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_q <= wr.data;
      end
    end

    assign head = mem_q;
  end else begin : g_ring
    localparam int             PW   = $clog2(DEPTH);
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

    TYPE           mem_q [DEPTH];
    logic [PW-1:0] wp_q;
    logic [PW-1:0] rp_q;

    // The pointers wrap explicitly at DEPTH-1, so DEPTH does not have to be a power of two.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wp_q <= '0;
        rp_q <= '0;
      end else if (flush) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (wr_en) begin
          wp_q <= (wp_q == LAST) ? '0 : wp_q + PW'(1);
        end
        if (rd_en) begin
          rp_q <= (rp_q == LAST) ? '0 : rp_q + PW'(1);
        end
      end
    end

    // The payload storage has no reset. Entries are only observable when count says they are valid.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_q[wp_q] <= wr.data;
      end
    end

    assign head = mem_q[rp_q];
  end

endmodule

// File: tb/tb_fifo_level.sv
module tb_fifo_level;

  localparam int NI = 4;

  // Instance set:
  //   0: DEPTH 5, no fall-through
  //   1: DEPTH 3, fall-through
  //   2: DEPTH 4, fall-through
  //   3: DEPTH 1, no fall-through (AF_LEVEL 0)
  function automatic int dep_of(input int i);
    case (i)
      0:       return 5;
      1:       return 3;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int ft_of(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]      wv;
  logic [NI-1:0]      rr;
  logic [NI-1:0]      fl;
  logic [NI-1:0][7:0] wd;

  logic [NI-1:0]      wr_o;
  logic [NI-1:0]      rv_o;
  logic [NI-1:0][7:0] rd_o;
  logic [NI-1:0][2:0] cnt_o;
  logic [NI-1:0]      af_o;
  logic [NI-1:0]      ae_o;
  logic [NI-1:0][2:0] pk_o;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D   = dep_of(g);
    localparam int CWG = $clog2(D + 1);

    fifo_level_if #(.TYPE(logic [7:0])) wif ();
    fifo_level_if #(.TYPE(logic [7:0])) rif ();

    logic [CWG-1:0] cnt;
    logic           af;
    logic           ae;

    assign wif.valid = wv[g];
    assign wif.data  = wd[g];
    assign rif.ready = rr[g];
    assign wr_o[g]   = wif.ready;
    assign rv_o[g]   = rif.valid;
    assign rd_o[g]   = rif.data;
    assign cnt_o[g]  = 3'(cnt);
    assign af_o[g]   = af;
    assign ae_o[g]   = ae;

`ifdef FIFO_LEVEL_PEAK_EN
    logic [CWG-1:0] pk;
    assign pk_o[g] = 3'(pk);
`else
    assign pk_o[g] = 3'd0;
`endif

    fifo_level #(
      .DATA_WIDTH  (8),
      .DEPTH       (D),
      .FALL_THROUGH(ft_of(g))
    ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .flush       (fl[g]),
      .wr          (wif),
      .rd          (rif),
      .count       (cnt),
      .almost_full (af),
      .almost_empty(ae)
`ifdef FIFO_LEVEL_PEAK_EN
      ,
      .peak        (pk)
`endif
    );
  end

  // Behavioural model: a circular list per instance (head index plus size), and the peak size.
  logic [7:0] mdat [NI][8];
  int         hd   [NI];
  int         sz   [NI];
  int         pkm  [NI];

  int vec  = 0;
  int miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare one instance against the model, then advance the model by the handshakes this cycle implies.
  task automatic check_inst(input int i);
    int         d;
    int         c;
    bit         ft;
    bit         ewr;
    bit         erv;
    bit         whs;
    bit         rhs;
    logic [7:0] ed;
    d  = dep_of(i);
    ft = (ft_of(i) != 0);
    if (!rstn) begin
      sz[i]  = 0;
      hd[i]  = 0;
      pkm[i] = 0;
    end
    c   = sz[i];
    ewr = !fl[i] && (c < d);
    erv = !fl[i] && ((c > 0) || (ft && wv[i]));
    ed  = (c > 0) ? mdat[i][hd[i]] : wd[i];
    chk($sformatf("i%0d_count", i), 32'(cnt_o[i]), 32'(c));
    chk($sformatf("i%0d_almost_full", i), 32'(af_o[i]), 32'(c >= d - 1));
    chk($sformatf("i%0d_almost_empty", i), 32'(ae_o[i]), 32'(c <= 1));
    chk($sformatf("i%0d_w_ready", i), 32'(wr_o[i]), 32'(ewr));
    chk($sformatf("i%0d_r_valid", i), 32'(rv_o[i]), 32'(erv));
    if (erv) chk($sformatf("i%0d_r_data", i), 32'(rd_o[i]), 32'(ed));
`ifdef FIFO_LEVEL_PEAK_EN
    chk($sformatf("i%0d_peak", i), 32'(pk_o[i]), 32'(pkm[i]));
`endif
    if (rstn) begin
      if (fl[i]) begin
        sz[i]  = 0;
        hd[i]  = 0;
        pkm[i] = 0;
      end else begin
        whs = wv[i] && ewr;
        rhs = erv && rr[i];
        if (!(c == 0 && whs && rhs)) begin
          if (rhs) begin
            hd[i] = (hd[i] + 1) % 8;
            sz[i] = sz[i] - 1;
          end
          if (whs) begin
            mdat[i][(hd[i] + sz[i]) % 8] = wd[i];
            sz[i] = sz[i] + 1;
          end
        end
        if (sz[i] > pkm[i]) pkm[i] = sz[i];
      end
    end
  endtask

  // Inputs are driven at posedge+1. Checks run at posedge+2. The task then returns at the next posedge+1.
  task automatic step();
    #1;
    for (int i = 0; i < NI; i++) check_inst(i);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    wv = '0;
    rr = '0;
    fl = '0;
  endtask

  initial begin
    idle_all();
    wd = '0;
    for (int i = 0; i < NI; i++) begin
      hd[i]  = 0;
      sz[i]  = 0;
      pkm[i] = 0;
    end

    // Reset: r_valid follows w_valid only for the fall-through instances.
    @(posedge clk);
    #1;
    wv[0] = 1'b1;
    wv[1] = 1'b1;
    wd[1] = 8'h3C;
    #1;
    chk("rst_r_valid_ft", 32'(rv_o[1]), 32'd1);
    chk("rst_r_valid_noft", 32'(rv_o[0]), 32'd0);
    chk("rst_af_af0", 32'(af_o[3]), 32'd1);
    chk("rst_ae", 32'(ae_o[0]), 32'd1);
    step();
    rstn = 1'b1;
    idle_all();
    step();

    // Instance 0, DEPTH 5: fill the FIFO, then drain it in order.
    for (int k = 1; k <= 5; k++) begin
      wv[0] = 1'b1;
      wd[0] = 8'(k);
      step();
      if (k == 4) begin
        chk("a_count4", 32'(cnt_o[0]), 32'd4);
        chk("a_af_at4", 32'(af_o[0]), 32'd1);
      end
    end
    chk("a_count5", 32'(cnt_o[0]), 32'd5);
    chk("a_w_ready_full", 32'(wr_o[0]), 32'd0);
    chk("model_a_size5", 32'(sz[0]), 32'd5);
    wv[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      rr[0] = 1'b1;
      #1;
      chk("a_read_order", 32'(rd_o[0]), 32'(k));
      step();
    end
    chk("a_count0", 32'(cnt_o[0]), 32'd0);
    idle_all();

    // Instance 1, DEPTH 3, fall-through: an empty FIFO with both handshakes bypasses storage.
    wv[1] = 1'b1;
    rr[1] = 1'b1;
    wd[1] = 8'hA5;
    #1;
    chk("b_bypass_r_valid", 32'(rv_o[1]), 32'd1);
    chk("b_bypass_r_data", 32'(rd_o[1]), 32'hA5);
    step();
    chk("b_bypass_count", 32'(cnt_o[1]), 32'd0);
    idle_all();

    // Instance 2, DEPTH 4: when full, a simultaneous read and write lets only the read through.
    for (int k = 0; k < 4; k++) begin
      wv[2] = 1'b1;
      wd[2] = 8'(8'h10 + k);
      step();
    end
    chk("d_count_full", 32'(cnt_o[2]), 32'd4);
    chk("d_w_ready_full", 32'(wr_o[2]), 32'd0);
    wd[2] = 8'h99;
    rr[2] = 1'b1;
    step();
    chk("d_count_after_rw", 32'(cnt_o[2]), 32'd3);
    chk("d_w_ready_rise", 32'(wr_o[2]), 32'd1);
    idle_all();
    // Flush at count 3 with both sides requesting: no handshake can complete.
    fl[2] = 1'b1;
    wv[2] = 1'b1;
    rr[2] = 1'b1;
    #1;
    chk("d_flush_w_ready", 32'(wr_o[2]), 32'd0);
    chk("d_flush_r_valid", 32'(rv_o[2]), 32'd0);
    step();
    chk("d_flush_count", 32'(cnt_o[2]), 32'd0);
    chk("d_flush_ae", 32'(ae_o[2]), 32'd1);
`ifdef FIFO_LEVEL_PEAK_EN
    chk("d_flush_peak", 32'(pk_o[2]), 32'd0);
`endif
    idle_all();

    // Instance 3, DEPTH 1: alternate a write and a read.
    for (int k = 0; k < 4; k++) begin
      wv[3] = (k % 2 == 0);
      rr[3] = (k % 2 == 1);
      wd[3] = 8'(8'h30 + k);
      step();
      chk("c_count_toggle", 32'(cnt_o[3]), 32'((k % 2 == 0) ? 1 : 0));
      chk("c_w_ready_not_count", 32'(wr_o[3]), 32'((k % 2 == 0) ? 0 : 1));
    end
    idle_all();
    step();

    // Randomised traffic on all instances, with occasional flushes and one reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      rstn = (n != 1500);
      for (int i = 0; i < NI; i++) begin
        wv[i] = ($urandom_range(0, 1) == 1);
        rr[i] = ($urandom_range(0, 1) == 1);
        fl[i] = (n != 1500) && ($urandom_range(0, 31) == 0);
        wd[i] = 8'($urandom);
      end
      step();
    end
    rstn = 1'b1;
    idle_all();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 Parameter DATA_WIDTH, default 1, payload width when TYPE is not overridden.
REQ-002 Parameter TYPE, default logic [DATA_WIDTH-1:0], payload type.
REQ-003 Parameter DEPTH, default 4, entry count; any integer >= 1, not restricted to powers of 2.
REQ-004 Parameter FALL_THROUGH, default 0, first-word fall-through when 1.
REQ-005 Parameter AF_LEVEL, default DEPTH-1, almost-full threshold; AE_LEVEL, default 1, almost-empty threshold.
REQ-006 Localparam CW = $clog2(DEPTH+1), occupancy width.
REQ-007 clk  input  1  clock; all state updates on its rising edge.
REQ-008 rstn  input  1  reset, asynchronous, active-low.
REQ-009 flush  input  1  synchronous discard of all stored entries.
REQ-010 w_valid  input  1; w_ready  output  1; w_data  input  TYPE  write handshake.
REQ-011 r_valid  output  1; r_ready  input  1; r_data  output  TYPE  read handshake.
REQ-012 count  output  CW  registered occupancy, 0..DEPTH.
REQ-013 almost_full  output  1  registered, high when count >= AF_LEVEL.
REQ-014 almost_empty  output  1  registered, high when count <= AE_LEVEL.

Function
REQ-015 Write handshake = w_valid && w_ready; read handshake = r_valid && r_ready; transfers occur only on handshake.
REQ-016 w_ready SHALL be high iff count < DEPTH and flush is low; no write when full, even with a simultaneous read.
REQ-017 r_valid SHALL be high iff flush is low and (count > 0 or (FALL_THROUGH and w_valid)).
REQ-018 r_data SHALL be the oldest stored entry, combinational from storage; when count == 0 and FALL_THROUGH=1, r_data SHALL equal w_data.
REQ-019 Write latency: an entry written into a non-empty FIFO, or any FIFO with FALL_THROUGH=0, is visible at r_data no earlier than the next cycle.
REQ-020 Fall-through bypass when empty, with both handshakes in the same cycle: no storage write, pointers and count unchanged.
REQ-021 Read and write pointers SHALL run 0..DEPTH-1 and wrap from DEPTH-1 to 0; no power-of-2 arithmetic.
REQ-022 count_next = count + write - read, excluding the bypass case; never outside 0..DEPTH.
REQ-023 Simultaneous read and write with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-024 almost_full and almost_empty SHALL be registered from count_next, so they track count with no additional lag.
REQ-025 flush high: pointers and count set to 0 next cycle; almost_full = (AF_LEVEL == 0); almost_empty = 1; stored data not cleared.
REQ-026 No handshake SHALL complete in a flush cycle, because w_ready and r_valid are both low.
REQ-027 DEPTH == 1 SHALL use single-entry storage without pointers, with identical port behaviour.
REQ-028 Elaboration SHALL fatal if DEPTH < 1, AF_LEVEL > DEPTH, or AE_LEVEL > DEPTH.

Reset
REQ-029 On rstn low: pointers 0, count 0, almost_full = (AF_LEVEL == 0), almost_empty 1; if FIFO_LEVEL_PEAK_EN is defined, peak 0.
REQ-030 During reset: w_ready 1, r_valid = FALL_THROUGH && w_valid; storage contents not reset.
REQ-031 Reset asserted mid-transfer discards all entries; the first post-reset write behaves as a write into an empty FIFO.

Configuration
REQ-032 With macro FIFO_LEVEL_PEAK_EN defined, output peak (CW bits) is added.
REQ-033 peak holds the maximum count_next since reset or flush, is registered, saturates at DEPTH, and is cleared to 0 by flush.
REQ-034 Without FIFO_LEVEL_PEAK_EN, the peak port and its register are absent and all other behaviour is identical.

Verification
REQ-035 DEPTH=5, FALL_THROUGH=0, write 5 without reads -> count 5, w_ready 0, almost_full 1 from count 4 (AF_LEVEL=4); read 5 -> data in order, count 0.
REQ-036 DEPTH=5, run 12 writes and 12 reads interleaved at 50% rate -> pointer wrap across 4->0 with data order preserved and no loss.
REQ-037 DEPTH=3, FALL_THROUGH=1, empty, w_valid=r_ready=1 with data 0xA5 -> r_valid 1 and r_data 0xA5 same cycle, count stays 0.
REQ-038 DEPTH=4 full, w_valid=r_ready=1 -> only the read completes, count becomes 3, w_ready rises next cycle.
REQ-039 count 3, flush with w_valid=r_ready=1 -> no handshake completes, next cycle count 0, almost_empty 1, peak 0 (macro defined).
REQ-040 DEPTH=1, alternate write and read for 4 transfers -> count toggles 1/0, w_ready = !count, data matches.
